// File: rtl/demux_pkg.sv
// Shared helpers for the registered 1-to-N stream demultiplexer.
// No logic of its own: constants, a state type and elaboration-time functions.
// Backpressure is handled in demux_stream and demux_chan_reg.
package demux_pkg;

    // Largest channel count any demux_stream instance may be built with.
    localparam int MAX_CHAN = 256;

    // Per-channel holding register state.
    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } chan_state_e;

    // Ceiling log2, used at elaboration to check that the select can address every channel.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Bit offset of channel k inside the flattened output data bus.
    function automatic int chan_slice(input int k, input int data_w);
        return k * data_w;
    endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry output register for a single demux channel (EMPTY/FULL).
// Latency: data loaded on a cycle is valid on the output the next cycle.
// Backpressure: free_o is high when empty or draining; load and drain may coincide.
module demux_chan_reg
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              free_o
);

    chan_state_e       state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;

    // State and payload registers; a reset discards any held beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CH_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // Next state: a load always wins (refill on drain keeps full throughput),
    // otherwise a drained entry empties; payload only changes on a load.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        unique case (state_q)
            CH_EMPTY: begin
                if (load_i) begin
                    state_d = CH_FULL;
                    data_d  = data_i;
                end
            end
            CH_FULL: begin
                if (load_i) begin
                    data_d = data_i;
                end else if (ready_i) begin
                    state_d = CH_EMPTY;
                end
            end
            default: state_d = CH_EMPTY;
        endcase
    end

    assign valid_o = (state_q == CH_FULL);
    assign data_o  = data_q;
    assign free_o  = (state_q == CH_EMPTY) || ready_i;

endmodule

// File: rtl/demux_stream.sv
// Registered 1-to-N valid/ready stream demultiplexer with broadcast and out-of-range drop counting.
// Latency: 1 clock from input acceptance to out_valid on the target channel(s).
// Backpressure: in_ready follows the target channel's free state (all channels for broadcast); drops never stall.
module demux_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3,
    parameter int N_OUT  = 8,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_bcast,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]        drop_cnt
);

    if (N_OUT < 1 || clog2(N_OUT) > SEL_W || N_OUT > MAX_CHAN) begin : g_bad_n_out
        $error("demux_stream: N_OUT must be in 1..2**SEL_W");
    end

    localparam logic [SEL_W:0] N_OUT_L = (SEL_W + 1)'(N_OUT);

    logic [N_OUT-1:0] free;
    logic [N_OUT-1:0] sel_oh;
    logic [N_OUT-1:0] load;
    logic             range_ok;
    logic             accept;
    logic [CNT_W-1:0] drop_q, drop_d;

    assign range_ok = ({1'b0, in_sel} < N_OUT_L);

    // Binary-to-one-hot decode of the select; out-of-range selects decode to all zeros.
    always_comb begin
        sel_oh = '0;
        for (int k = 0; k < N_OUT; k++) begin
            sel_oh[k] = (in_sel == SEL_W'(k));
        end
    end

    // Input ready: all channels free for broadcast, target channel free otherwise,
    // and always ready for out-of-range beats since they are dropped. Independent of in_valid.
    always_comb begin
        in_ready = 1'b1;
        if (in_bcast) begin
            in_ready = &free;
        end else if (range_ok) begin
            in_ready = |(sel_oh & free);
        end
    end

    assign accept = in_valid && in_ready;
    assign load   = accept ? (in_bcast ? {N_OUT{1'b1}} : sel_oh) : '0;

    // Drop counter next value: saturating increment on each accepted out-of-range beat.
    always_comb begin
        drop_d = drop_q;
        if (accept && !in_bcast && !range_ok && (drop_q != {CNT_W{1'b1}})) begin
            drop_d = drop_q + 1'b1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt = drop_q;

    for (genvar k = 0; k < N_OUT; k++) begin : g_chan
        demux_chan_reg #(
            .DATA_W (DATA_W)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .load_i  (load[k]),
            .data_i  (in_data),
            .ready_i (out_ready[k]),
            .valid_o (out_valid[k]),
            .data_o  (out_data[chan_slice(k, DATA_W) +: DATA_W]),
            .free_o  (free[k])
        );
    end

endmodule
